// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one TL-UL device port among N hosts, with an
// in-order FIFO of granted host indices to route D-channel responses back.
package tlul_host_arb_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter  int N              = 2,
  parameter  int MaxOutstanding = 2,
  localparam int IdxW           = (N > 1) ? $clog2(N) : 1,
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t         tl_h_i [N],
  output tl_d2h_t         tl_h_o [N],
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            unexp_rsp_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] rr_ptr, lock_idx, grant_idx, head;
  logic            lock, grant_valid, full, empty, a_hs, d_hs;
  logic [IdxW-1:0] fifo [MaxOutstanding];
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;

  assign full  = (count == CntW'(MaxOutstanding));
  assign empty = (count == '0);
  assign head  = fifo[rd_ptr];

  // Descending scan so the host closest to rr_ptr is the last (winning) write.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (lock) begin
      grant_valid = 1'b1;
      grant_idx   = lock_idx;
    end else if (!full) begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr) + k) % N;
        if (tl_h_i[cand].a_valid) begin
          grant_valid = 1'b1;
          grant_idx   = IdxW'(cand);
        end
      end
    end
  end

  assign a_hs = grant_valid & tl_h_i[grant_idx].a_valid & tl_d_i.a_ready;
  assign d_hs = ~empty & tl_d_i.d_valid & tl_h_i[head].d_ready;

  always_comb begin
    tl_d_o = '0;
    if (grant_valid) tl_d_o = tl_h_i[grant_idx];
    tl_d_o.d_ready = ~empty & tl_h_i[head].d_ready;
    for (int i = 0; i < N; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = grant_valid & (grant_idx == IdxW'(i)) & tl_d_i.a_ready;
      tl_h_o[i].d_valid = ~empty & (head == IdxW'(i)) & tl_d_i.d_valid;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr      <= '0;
      lock        <= 1'b0;
      lock_idx    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      unexp_rsp_o <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) fifo[i] <= '0;
    end else begin
      if (a_hs) begin
        lock         <= 1'b0;
        fifo[wr_ptr] <= grant_idx;
        wr_ptr       <= (wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr + 1'b1;
        rr_ptr       <= (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end else if (grant_valid && tl_h_i[grant_idx].a_valid) begin
        // Stalled request: pin the grant so the A payload stays stable.
        lock     <= 1'b1;
        lock_idx <= grant_idx;
      end
      if (d_hs) begin
        rd_ptr <= (rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({a_hs, d_hs})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (empty && tl_d_i.d_valid) unexp_rsp_o <= 1'b1;
    end
  end

  assign outstanding_o = count;

endmodule

// File: tb/tb_tlul_host_arb.sv
// Scoreboard bench for tlul_host_arb: bench-side host drivers and an in-order
// device model; grants and responses are checked against pushed expectations.
module tb_tlul_host_arb;
  import tlul_host_arb_pkg::*;

  typedef struct packed {
    logic [3:0]  host;
    logic [31:0] val;
  } exp_t;

  logic        clk, rst_n;
  tl_h2d_t     h_i [2];
  tl_d2h_t     h_o [2];
  tl_h2d_t     d_o;
  tl_d2h_t     d_i;
  logic [1:0]  outstanding;
  logic        unexp;

  logic        a_valid_r [2];
  logic [31:0] addr_r [2];
  logic        d_ready_r [2];
  logic        dev_a_ready, dev_hold, dev_inject, dev_d_valid;
  logic [31:0] dev_d_data;

  logic [31:0] hq0 [$];
  logic [31:0] hq1 [$];
  logic [31:0] dq [$];
  exp_t        sb_q [$];
  exp_t        grant_q [$];

  int num_checks = 0;
  int num_fails  = 0;

  tlul_host_arb #(.N(2), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o),
    .tl_d_o(d_o), .tl_d_i(d_i), .outstanding_o(outstanding), .unexp_rsp_o(unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rsp(input logic [31:0] addr);
    return addr ^ 32'hDEADBFEF;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      h_i[i]           = '0;
      h_i[i].a_valid   = a_valid_r[i];
      h_i[i].a_opcode  = 3'd4;
      h_i[i].a_size    = 2'd2;
      h_i[i].a_mask    = 4'hF;
      h_i[i].a_source  = 8'(i);
      h_i[i].a_address = addr_r[i];
      h_i[i].d_ready   = d_ready_r[i];
    end
    d_i          = '0;
    d_i.a_ready  = dev_a_ready;
    d_i.d_valid  = dev_d_valid;
    d_i.d_opcode = 3'd1;
    d_i.d_data   = dev_d_data;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int host, input logic [31:0] addr);
    if (host == 0) hq0.push_back(addr);
    else hq1.push_back(addr);
    grant_q.push_back('{host: 4'(host), val: addr});
    sb_q.push_back('{host: 4'(host), val: rsp(addr)});
  endtask

  task automatic waitIdle(input string tag);
    int k;
    k = 0;
    while (k < 200 && !(hq0.size() == 0 && hq1.size() == 0 && sb_q.size() == 0 && outstanding == 0)) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_drain"}, 64'(k < 200), 64'd1);
  endtask

  // Host drivers: present the head of each host queue until it is accepted.
  initial begin
    logic hs0, hs1;
    for (int i = 0; i < 2; i++) begin
      a_valid_r[i] = 1'b0;
      addr_r[i]    = '0;
    end
    forever begin
      @(negedge clk);
      hs0 = h_i[0].a_valid && h_o[0].a_ready;
      hs1 = h_i[1].a_valid && h_o[1].a_ready;
      @(posedge clk);
      #2;
      if (rst_n && hs0 && hq0.size() > 0) void'(hq0.pop_front());
      if (rst_n && hs1 && hq1.size() > 0) void'(hq1.pop_front());
      a_valid_r[0] = hq0.size() > 0;
      addr_r[0]    = (hq0.size() > 0) ? hq0[0] : 32'h0;
      a_valid_r[1] = hq1.size() > 0;
      addr_r[1]    = (hq1.size() > 0) ? hq1[0] : 32'h0;
    end
  end

  // In-order device: answers each accepted request one cycle later unless held.
  initial begin
    logic ahs, dhs;
    logic [31:0] aaddr;
    dev_d_valid = 1'b0;
    dev_d_data  = '0;
    forever begin
      @(negedge clk);
      ahs   = d_o.a_valid && dev_a_ready;
      aaddr = d_o.a_address;
      dhs   = dev_d_valid && d_o.d_ready && !dev_inject;
      @(posedge clk);
      #2;
      if (!rst_n) dq.delete();
      else begin
        if (dhs && dq.size() > 0) void'(dq.pop_front());
        if (ahs) dq.push_back(aaddr);
      end
      dev_d_valid = (!dev_hold && dq.size() > 0) || dev_inject;
      dev_d_data  = dev_inject ? 32'hBAD0BAD0 : ((dq.size() > 0) ? rsp(dq[0]) : 32'h0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (h_i[i].a_valid && h_o[i].a_ready) begin
          if (grant_q.size() == 0) checkOutput("grant_unexpected", 64'(i), 64'hF);
          else begin
            e = grant_q.pop_front();
            checkOutput("grant_host", 64'(i), 64'(e.host));
            checkOutput("grant_addr", 64'(d_o.a_address), 64'(e.val));
          end
        end
      end
      if (h_o[0].d_valid && h_o[1].d_valid) checkOutput("dvalid_onehot", 64'd2, 64'd1);
      for (int i = 0; i < 2; i++) begin
        if (h_o[i].d_valid && d_ready_r[i]) begin
          if (sb_q.size() == 0) checkOutput("rsp_unexpected", 64'(i), 64'hF);
          else begin
            e = sb_q.pop_front();
            checkOutput("rsp_host", 64'(i), 64'(e.host));
            checkOutput("rsp_data", 64'(h_o[i].d_data), 64'(e.val));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    d_ready_r[0] = 1'b1;
    d_ready_r[1] = 1'b1;
    dev_a_ready  = 1'b1;
    dev_hold     = 1'b0;
    dev_inject   = 1'b0;

    @(negedge clk);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_unexp", 64'(unexp), 64'd0);
    checkOutput("rst_a_valid", 64'(d_o.a_valid), 64'd0);
    checkOutput("rst_d_ready", 64'(d_o.d_ready), 64'd0);
    checkOutput("rst_h0_a_ready", 64'(h_o[0].a_ready), 64'd0);
    checkOutput("rst_h0_d_valid", 64'(h_o[0].d_valid), 64'd0);
    checkOutput("rst_h1_d_valid", 64'(h_o[1].d_valid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single transaction from host0.
    @(posedge clk); #1 applyStimulus(0, 32'h100);
    @(negedge clk);
    checkOutput("single_a_valid", 64'(d_o.a_valid), 64'd1);
    checkOutput("single_addr", 64'(d_o.a_address), 64'h100);
    checkOutput("single_out0", 64'(outstanding), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("single_out1", 64'(outstanding), 64'd1);
    checkOutput("single_h0_dvalid", 64'(h_o[0].d_valid), 64'd1);
    checkOutput("single_h0_data", 64'(h_o[0].d_data), 64'hDEADBEEF);
    checkOutput("single_h1_dvalid", 64'(h_o[1].d_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("single_out_end", 64'(outstanding), 64'd0);
    waitIdle("single");

    // Contention from a fresh rr_ptr of 0: expect 0,1,0,1.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(0, 32'h110);
    applyStimulus(1, 32'h120);
    applyStimulus(0, 32'h118);
    applyStimulus(1, 32'h128);
    waitIdle("contention");

    // Lock: host1 stalled for 3 cycles while host0 (rr favourite) joins.
    @(posedge clk); #1;
    dev_a_ready = 1'b0;
    applyStimulus(1, 32'h210);
    @(negedge clk);
    checkOutput("lock_c1_addr", 64'(d_o.a_address), 64'h210);
    @(posedge clk); #1 applyStimulus(0, 32'h200);
    @(negedge clk);
    checkOutput("lock_c2_addr", 64'(d_o.a_address), 64'h210);
    checkOutput("lock_c2_h0_ready", 64'(h_o[0].a_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lock_c3_addr", 64'(d_o.a_address), 64'h210);
    checkOutput("lock_c3_valid", 64'(d_o.a_valid), 64'd1);
    @(posedge clk); #1 dev_a_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lock_next_addr", 64'(d_o.a_address), 64'h200);
    checkOutput("lock_next_h0_ready", 64'(h_o[0].a_ready), 64'd1);
    waitIdle("lock");

    // FIFO full: two accepted with responses held, third must wait.
    @(posedge clk); #1;
    dev_hold = 1'b1;
    applyStimulus(1, 32'h420);
    applyStimulus(0, 32'h400);
    applyStimulus(0, 32'h408);
    for (int k = 0; k < 20 && outstanding != 2'd2; k++) @(negedge clk);
    checkOutput("full_outstanding", 64'(outstanding), 64'd2);
    checkOutput("full_a_valid", 64'(d_o.a_valid), 64'd0);
    @(posedge clk); #1 dev_hold = 1'b0;
    @(negedge clk);
    checkOutput("full_pop_a_valid", 64'(d_o.a_valid), 64'd0);
    checkOutput("full_pop_d_ready", 64'(d_o.d_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("full_resume_valid", 64'(d_o.a_valid), 64'd1);
    checkOutput("full_resume_addr", 64'(d_o.a_address), 64'h408);
    waitIdle("full");

    // D-channel backpressure from host0.
    @(posedge clk); #1;
    d_ready_r[0] = 1'b0;
    applyStimulus(0, 32'h500);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("dbp_d_ready", 64'(d_o.d_ready), 64'd0);
      checkOutput("dbp_h0_dvalid", 64'(h_o[0].d_valid), 64'd1);
      checkOutput("dbp_outstanding", 64'(outstanding), 64'd1);
    end
    @(posedge clk); #1 d_ready_r[0] = 1'b1;
    @(negedge clk);
    checkOutput("dbp_release", 64'(d_o.d_ready), 64'd1);
    waitIdle("dbp");

    // Unexpected response with the FIFO empty.
    @(posedge clk); #1 dev_inject = 1'b1;
    @(negedge clk);
    checkOutput("unexp_h0_dvalid", 64'(h_o[0].d_valid), 64'd0);
    checkOutput("unexp_h1_dvalid", 64'(h_o[1].d_valid), 64'd0);
    checkOutput("unexp_d_ready", 64'(d_o.d_ready), 64'd0);
    @(posedge clk); #1 dev_inject = 1'b0;
    @(negedge clk);
    checkOutput("unexp_set", 64'(unexp), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("unexp_hold", 64'(unexp), 64'd1);

    // Reset mid-operation: one outstanding, host1 locked, host0 waiting.
    @(posedge clk); #1;
    dev_hold = 1'b1;
    applyStimulus(1, 32'h600);
    for (int k = 0; k < 20 && outstanding != 2'd1; k++) @(negedge clk);
    checkOutput("mid_outstanding", 64'(outstanding), 64'd1);
    @(posedge clk); #1;
    dev_a_ready = 1'b0;
    hq1.push_back(32'h610);
    @(posedge clk); #1 hq0.push_back(32'h620);
    @(negedge clk);
    checkOutput("mid_lock_addr", 64'(d_o.a_address), 64'h610);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("mid_rst_unexp", 64'(unexp), 64'd0);
    checkOutput("mid_rst_unlocked_addr", 64'(d_o.a_address), 64'h620);
    @(posedge clk); #1;
    hq0.delete();
    hq1.delete();
    sb_q.delete();
    grant_q.delete();
    dev_hold    = 1'b0;
    dev_a_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_a_valid", 64'(d_o.a_valid), 64'd0);
    checkOutput("post_grant_q_empty", 64'(grant_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/tlul_host_arb.md
Name: tlul_host_arb

Overview:
Round-robin arbiter that shares one TL-UL device port between N TL-UL hosts, e.g. the Ibex data and instruction ports in front of the SoC crossbar. It grants the A channel to one host at a time and records the granted host index in an in-order response-tracking FIFO. It routes each D-channel response back to the host at the FIFO head. It requires an in-order device: one response per accepted request, in acceptance order.

Parameters:
N, 2, number of host ports (2..8)
MaxOutstanding, 2, depth of the response-tracking FIFO; maximum accepted-but-unanswered requests (1..8)
IdxW, $clog2(N) (min 1), width of a host index (derived)
CntW, $clog2(MaxOutstanding+1), width of the outstanding counter (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
tl_h_i  in  tl_h2d_t [N]  host requests
tl_h_o  out  tl_d2h_t [N]  host responses
tl_d_o  out  tl_h2d_t  request to device
tl_d_i  in  tl_d2h_t  response from device
outstanding_o  out  CntW  current FIFO occupancy
unexp_rsp_o  out  1  sticky flag: device d_valid seen while FIFO empty

Behaviour:
- Reset: rr_ptr=0, lock=0, FIFO empty (rd/wr ptr 0, count 0), unexp_rsp_o=0.
- At reset, all tl_h_o a_ready=0 and d_valid=0. tl_d_o a_valid=0. tl_d_o d_ready=0 because the FIFO is empty.
- Request eligibility: host i is eligible when tl_h_i[i].a_valid=1 and FIFO is not full (count<MaxOutstanding). A full FIFO blocks all grants.
- Grant selection when lock=0: first eligible host scanning rr_ptr, rr_ptr+1, ... mod N. This is combinational, so there is zero cycles of latency from a_valid to tl_d_o.a_valid.
- When lock=1, the grant is held on the registered lock_idx regardless of other requesters.
- A-channel pass-through: tl_d_o carries the granted host's a_* fields unmodified, a_valid included.
  - tl_h_o[g].a_ready = tl_d_i.a_ready.
  - For non-granted hosts, a_ready=0.
  - With no grant, tl_d_o.a_valid=0.
- Lock:
  - Granted a_valid=1 and a_ready=0 sets lock=1 and lock_idx=g, so the A payload stays stable per TL-UL.
  - Handshake (a_valid & a_ready) clears lock.
  - Lock cannot be set while the FIFO is full, because no grant is issued.
- Accept: on the A handshake, push g into the FIFO and set rr_ptr=(g+1) mod N. rr_ptr is unchanged otherwise.
- D-channel routing: head = FIFO[rd_ptr].
  - If the FIFO is non-empty: tl_h_o[head].d_* = tl_d_i.d_*, and tl_d_o.d_ready = tl_h_i[head].d_ready.
  - Other hosts have d_valid=0. Their d_* data fields are driven with tl_d_i values but are ignored.
  - On d_valid & d_ready, pop the FIFO.
- Empty FIFO: tl_d_o.d_ready=0 and no host sees d_valid. If tl_d_i.d_valid=1, unexp_rsp_o is set and holds until reset.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Full FIFO with a pop in the same cycle: no new grant that cycle, because eligibility uses the registered count. A grant is possible the next cycle.
- Pointers wrap modulo MaxOutstanding. Non-power-of-two depth uses explicit wrap compare.
- outstanding_o = registered count, ranging 0..MaxOutstanding.
- Reset mid-operation (rst_ni low at any time): all state returns to reset values asynchronously. Pending responses are dropped.

Test Plan:
- Single host (N=2, host0): Get to 0x100 with a_ready=1, response 1 cycle later with d_data=0xDEADBEEF. Required: tl_d_o.a_address=0x100 in the same cycle; outstanding_o 0->1->0; host0 gets d_valid with 0xDEADBEEF; host1 d_valid=0 throughout.
- Contention: both hosts hold a_valid for 4 accepts with a_ready=1. Required: grant order 0,1,0,1; FIFO contents 0,1,0,1; responses delivered to hosts 0,1,0,1.
- Backpressure lock: host1 granted with a_ready=0 for 3 cycles while host0 raises a_valid in cycle 2. Required: tl_d_o address stays host1's for all 3 cycles; host0 a_ready=0; host0 is granted right after host1 is accepted.
- FIFO full (MaxOutstanding=2): 2 requests accepted with no responses. Required: outstanding_o=2; a third a_valid sees tl_d_o.a_valid=0. After one response pops, the grant resumes the next cycle.
- D backpressure: host0 holds d_ready=0 for 2 cycles while the device holds d_valid. Required: tl_d_o.d_ready=0 for those cycles; no pop; delivery on the third cycle.
- Unexpected response and reset: d_valid with FIFO empty -> unexp_rsp_o=1 and held. Then rst_ni=0 with 1 outstanding -> outstanding_o=0, unexp_rsp_o=0, and lock is cleared immediately.
